game_ctrl: RTL and testbench

GAME_CTRL -- requirements
Module: game_ctrl

---
 rtl/game_ctrl.sv | 217 +++++++++++++++++++++
 tb/tb_game_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/game_ctrl.sv
// game_ctrl: top-level game sequencer for the bar/ball display game.
// Synchronises the asynchronous button, vertical-sync and miss inputs,
// turns their rising edges into single-clock pulses, and runs the
// IDLE/SERVE/PLAY/OVER sequence that owns lives, score and speed.
module game_ctrl #(
  parameter int LIVES_INIT   = 3,
  parameter int SPEED_INIT   = 1,
  parameter int SPEED_MAX    = 8,
  parameter int SERVE_FRAMES = 60,
  parameter int LEVEL_FRAMES = 600
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_btn,
  input  logic       vs,
  input  logic       lose,
  output logic [3:0] bar_move_speed,
  output logic       ball_reset,
  output logic [1:0] lives,
  output logic [7:0] score,
  output logic       game_over,
  output logic [1:0] state
);

  // State encoding as seen on the state output.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SERVE = 2'd1;
  localparam logic [1:0] ST_PLAY  = 2'd2;
  localparam logic [1:0] ST_OVER  = 2'd3;

  // Parameter values narrowed once to the widths of the registers they load.
  localparam logic [1:0] C_LIVES_INIT = 2'(LIVES_INIT);
  localparam logic [3:0] C_SPEED_INIT = 4'(SPEED_INIT);
  localparam logic [3:0] C_SPEED_MAX  = 4'(SPEED_MAX);
  localparam logic [9:0] C_SERVE_LAST = 10'(SERVE_FRAMES - 1);
  localparam logic [9:0] C_LEVEL_LAST = 10'(LEVEL_FRAMES - 1);
  localparam logic [7:0] C_SCORE_MAX  = 8'd255;

  // Input bit positions inside the synchroniser vectors.
  localparam int I_START = 0;
  localparam int I_VS    = 1;
  localparam int I_LOSE  = 2;

  // ------------------------------------------------------------------
  // Input conditioning
  // ------------------------------------------------------------------
  logic [2:0] w_in;
  logic [2:0] r_sync1;
  logic [2:0] r_sync2;
  logic [2:0] r_dly;
  logic [2:0] r_pulse;
  logic [2:0] r_armed;
  logic [1:0] r_settle;
  logic       w_settled;

  assign w_in      = {lose, vs, start_btn};
  // The second synchroniser stage only reflects the pins once two clocks
  // have passed since reset release.
  assign w_settled = (r_settle == 2'd2);

  // Two-flop synchroniser, delay flop and registered rising-edge pulse.
  // An input is only armed after it has been seen low following reset,
  // so a level that is already high when reset releases never pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1  <= 3'b000;
      r_sync2  <= 3'b000;
      r_dly    <= 3'b000;
      r_pulse  <= 3'b000;
      r_armed  <= 3'b000;
      r_settle <= 2'd0;
    end else begin
      r_sync1  <= w_in;
      r_sync2  <= r_sync1;
      r_dly    <= r_sync2;
      r_pulse  <= r_sync2 & ~r_dly & r_armed;
      r_armed  <= r_armed | ({3{w_settled}} & ~r_sync2);
      r_settle <= w_settled ? r_settle : (r_settle + 2'd1);
    end
  end

  logic w_start_p;
  logic w_frame_p;
  logic w_lose_p;

  assign w_start_p = r_pulse[I_START];
  assign w_frame_p = r_pulse[I_VS];
  assign w_lose_p  = r_pulse[I_LOSE];

  // ------------------------------------------------------------------
  // Game sequencer
  // ------------------------------------------------------------------
  logic [1:0] r_state;
  logic [1:0] r_lives;
  logic [7:0] r_score;
  logic [3:0] r_speed;
  logic [9:0] r_cnt;
  logic [3:0] r_bar_speed;
  logic       r_ball_reset;
  logic       r_game_over;

  logic [1:0] w_state_nxt;
  logic [1:0] w_lives_nxt;
  logic [7:0] w_score_nxt;
  logic [3:0] w_speed_nxt;
  logic [9:0] w_cnt_nxt;
  logic       w_ball_reset_nxt;
  logic [7:0] w_score_inc;
  logic [3:0] w_speed_inc;

  // Saturating increments used on every level-up.
  assign w_score_inc = (r_score == C_SCORE_MAX) ? C_SCORE_MAX : (r_score + 8'd1);
  assign w_speed_inc = (r_speed >= C_SPEED_MAX) ? C_SPEED_MAX : (r_speed + 4'd1);

  // Next-state and datapath decisions; a loss always takes priority over
  // a level-up arriving in the same clock.
  always_comb begin
    w_state_nxt      = r_state;
    w_lives_nxt      = r_lives;
    w_score_nxt      = r_score;
    w_speed_nxt      = r_speed;
    w_cnt_nxt        = r_cnt;
    w_ball_reset_nxt = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_lives_nxt = C_LIVES_INIT;
        w_score_nxt = 8'd0;
        w_speed_nxt = C_SPEED_INIT;
        w_cnt_nxt   = 10'd0;
        if (w_start_p) begin
          w_state_nxt      = ST_SERVE;
          w_ball_reset_nxt = 1'b1;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_SERVE: begin
        if (w_frame_p) begin
          if (r_cnt >= C_SERVE_LAST) begin
            w_cnt_nxt   = 10'd0;
            w_state_nxt = ST_PLAY;
          end else begin
            w_cnt_nxt = r_cnt + 10'd1;
          end
        end else begin
          w_cnt_nxt = r_cnt;
        end
      end
      ST_PLAY: begin
        if (w_lose_p) begin
          w_cnt_nxt = 10'd0;
          if (r_lives > 2'd1) begin
            w_lives_nxt      = r_lives - 2'd1;
            w_ball_reset_nxt = 1'b1;
            w_state_nxt      = ST_SERVE;
          end else begin
            w_lives_nxt = 2'd0;
            w_state_nxt = ST_OVER;
          end
        end else if (w_frame_p) begin
          if (r_cnt >= C_LEVEL_LAST) begin
            w_cnt_nxt   = 10'd0;
            w_score_nxt = w_score_inc;
            w_speed_nxt = w_speed_inc;
          end else begin
            w_cnt_nxt = r_cnt + 10'd1;
          end
        end else begin
          w_cnt_nxt = r_cnt;
        end
      end
      ST_OVER: begin
        if (w_start_p) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_OVER;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = 10'd0;
      end
    endcase
  end

  // Game state registers plus the registered copies of the outputs, which
  // are derived from the next state so they move together with state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_lives      <= C_LIVES_INIT;
      r_score      <= 8'd0;
      r_speed      <= C_SPEED_INIT;
      r_cnt        <= 10'd0;
      r_bar_speed  <= 4'd0;
      r_ball_reset <= 1'b0;
      r_game_over  <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_lives      <= w_lives_nxt;
      r_score      <= w_score_nxt;
      r_speed      <= w_speed_nxt;
      r_cnt        <= w_cnt_nxt;
      r_bar_speed  <= (w_state_nxt == ST_PLAY) ? w_speed_nxt : 4'd0;
      r_ball_reset <= w_ball_reset_nxt;
      r_game_over  <= (w_state_nxt == ST_OVER);
    end
  end

  assign bar_move_speed = r_bar_speed;
  assign ball_reset     = r_ball_reset;
  assign lives          = r_lives;
  assign score          = r_score;
  assign game_over      = r_game_over;
  assign state          = r_state;

endmodule

// File: tb/tb_game_ctrl.sv
// tb_game_ctrl: directed self-checking bench for game_ctrl with the
// default parameters (3 lives, speed 1..8, 60 serve frames, 600 per level).
module tb_game_ctrl;

  logic       clk;
  logic       rst_n;
  logic       start_btn;
  logic       vs;
  logic       lose;
  logic [3:0] bar_move_speed;
  logic       ball_reset;
  logic [1:0] lives;
  logic [7:0] score;
  logic       game_over;
  logic [1:0] state;

  int n_checks;
  int n_fail;

  game_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start_btn      (start_btn),
    .vs             (vs),
    .lose           (lose),
    .bar_move_speed (bar_move_speed),
    .ball_reset     (ball_reset),
    .lives          (lives),
    .score          (score),
    .game_over      (game_over),
    .state          (state)
  );

  // 100 MHz clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Advance n cycles, counting cycles on which ball_reset is high.
  task automatic step_count(input int n, output int br);
    br = 0;
    repeat (n) begin
      @(negedge clk);
      if (ball_reset === 1'b1) br++;
    end
  endtask

  // n rising edges of vs, 4 clocks apart.
  task automatic vs_edges(input int n);
    repeat (n) begin
      vs = 1'b1;
      step(2);
      vs = 1'b0;
      step(2);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start_btn = 1'b0; vs = 1'b0; lose = 1'b0;
    step(3);
    n_checks++; if (state !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", state); end
    n_checks++; if (lives !== 2'd3) begin n_fail++; $display("FAIL reset_lives: got %0d expected 3", lives); end
    n_checks++; if (score !== 8'd0) begin n_fail++; $display("FAIL reset_score: got %0d expected 0", score); end
    n_checks++; if (bar_move_speed !== 4'd0) begin n_fail++; $display("FAIL reset_speed: got %0d expected 0", bar_move_speed); end
    n_checks++; if (ball_reset !== 1'b0) begin n_fail++; $display("FAIL reset_ball_reset: got %0d expected 0", ball_reset); end
    n_checks++; if (game_over !== 1'b0) begin n_fail++; $display("FAIL reset_game_over: got %0d expected 0", game_over); end
    rst_n = 1'b1;
    step(5);
  endtask

  task automatic test_start;
    int first;
    int cnt;
    first = 0; cnt = 0;
    start_btn = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (ball_reset === 1'b1) begin
        cnt++;
        if (first == 0) first = k;
      end
    end
    n_checks++; if (first !== 4) begin n_fail++; $display("FAIL start_latency: got %0d expected 4", first); end
    n_checks++; if (cnt !== 1) begin n_fail++; $display("FAIL start_ball_reset_len: got %0d expected 1", cnt); end
    n_checks++; if (state !== 2'd1) begin n_fail++; $display("FAIL start_state: got %0d expected 1", state); end
    n_checks++; if (bar_move_speed !== 4'd0) begin n_fail++; $display("FAIL start_speed: got %0d expected 0", bar_move_speed); end
    start_btn = 1'b0;
    vs_edges(59); step(3);
    n_checks++; if (state !== 2'd1) begin n_fail++; $display("FAIL serve_59: got %0d expected 1", state); end
    vs_edges(1); step(3);
    n_checks++; if (state !== 2'd2) begin n_fail++; $display("FAIL serve_60_state: got %0d expected 2", state); end
    n_checks++; if (bar_move_speed !== 4'd1) begin n_fail++; $display("FAIL serve_60_speed: got %0d expected 1", bar_move_speed); end
  endtask

  task automatic test_level;
    vs_edges(599); step(3);
    n_checks++; if (score !== 8'd0) begin n_fail++; $display("FAIL level_599_score: got %0d expected 0", score); end
    vs_edges(1); step(3);
    n_checks++; if (score !== 8'd1) begin n_fail++; $display("FAIL level_1_score: got %0d expected 1", score); end
    n_checks++; if (bar_move_speed !== 4'd2) begin n_fail++; $display("FAIL level_1_speed: got %0d expected 2", bar_move_speed); end
    vs_edges(600); step(3);
    n_checks++; if (score !== 8'd2) begin n_fail++; $display("FAIL level_2_score: got %0d expected 2", score); end
    n_checks++; if (bar_move_speed !== 4'd3) begin n_fail++; $display("FAIL level_2_speed: got %0d expected 3", bar_move_speed); end
    vs_edges(4800); step(3);
    n_checks++; if (score !== 8'd10) begin n_fail++; $display("FAIL level_10_score: got %0d expected 10", score); end
    n_checks++; if (bar_move_speed !== 4'd8) begin n_fail++; $display("FAIL level_10_speed_sat: got %0d expected 8", bar_move_speed); end
  endtask

  task automatic test_loss;
    int br;
    lose = 1'b1;
    step_count(10, br);
    n_checks++; if (br !== 1) begin n_fail++; $display("FAIL loss_ball_reset: got %0d expected 1", br); end
    n_checks++; if (lives !== 2'd2) begin n_fail++; $display("FAIL loss_lives: got %0d expected 2", lives); end
    n_checks++; if (state !== 2'd1) begin n_fail++; $display("FAIL loss_state: got %0d expected 1", state); end
    n_checks++; if (score !== 8'd10) begin n_fail++; $display("FAIL loss_score_kept: got %0d expected 10", score); end
    vs_edges(60); step(3);
    n_checks++; if (state !== 2'd2) begin n_fail++; $display("FAIL loss_replay_state: got %0d expected 2", state); end
    n_checks++; if (bar_move_speed !== 4'd8) begin n_fail++; $display("FAIL loss_speed_kept: got %0d expected 8", bar_move_speed); end
    step(20);
    n_checks++; if (lives !== 2'd2) begin n_fail++; $display("FAIL loss_held_lives: got %0d expected 2", lives); end
  endtask

  task automatic test_collision;
    int br;
    lose = 1'b0;
    step(4);
    vs_edges(599);
    vs = 1'b1; lose = 1'b1;
    step(2);
    vs = 1'b0;
    step_count(6, br);
    n_checks++; if (lives !== 2'd1) begin n_fail++; $display("FAIL collide_lives: got %0d expected 1", lives); end
    n_checks++; if (score !== 8'd10) begin n_fail++; $display("FAIL collide_score: got %0d expected 10", score); end
    n_checks++; if (state !== 2'd1) begin n_fail++; $display("FAIL collide_state: got %0d expected 1", state); end
    n_checks++; if (br !== 1) begin n_fail++; $display("FAIL collide_ball_reset: got %0d expected 1", br); end
  endtask

  task automatic test_over;
    int br;
    lose = 1'b0;
    step(4);
    vs_edges(60); step(3);
    n_checks++; if (state !== 2'd2) begin n_fail++; $display("FAIL over_pre_state: got %0d expected 2", state); end
    lose = 1'b1;
    step_count(10, br);
    n_checks++; if (lives !== 2'd0) begin n_fail++; $display("FAIL over_lives: got %0d expected 0", lives); end
    n_checks++; if (state !== 2'd3) begin n_fail++; $display("FAIL over_state: got %0d expected 3", state); end
    n_checks++; if (game_over !== 1'b1) begin n_fail++; $display("FAIL over_flag: got %0d expected 1", game_over); end
    n_checks++; if (bar_move_speed !== 4'd0) begin n_fail++; $display("FAIL over_speed: got %0d expected 0", bar_move_speed); end
    n_checks++; if (br !== 0) begin n_fail++; $display("FAIL over_no_ball_reset: got %0d expected 0", br); end
    n_checks++; if (score !== 8'd10) begin n_fail++; $display("FAIL over_score_held: got %0d expected 10", score); end
    lose = 1'b0;
    step(4);
    start_btn = 1'b1;
    step(4);
    n_checks++; if (state !== 2'd0) begin n_fail++; $display("FAIL restart_state: got %0d expected 0", state); end
    n_checks++; if (game_over !== 1'b0) begin n_fail++; $display("FAIL restart_flag: got %0d expected 0", game_over); end
    step(1);
    n_checks++; if (lives !== 2'd3) begin n_fail++; $display("FAIL restart_lives: got %0d expected 3", lives); end
    n_checks++; if (score !== 8'd0) begin n_fail++; $display("FAIL restart_score: got %0d expected 0", score); end
    start_btn = 1'b0;
  endtask

  task automatic test_midgame_reset;
    int br;
    step(4);
    start_btn = 1'b1;
    step(6);
    n_checks++; if (state !== 2'd1) begin n_fail++; $display("FAIL mid_serve_state: got %0d expected 1", state); end
    vs_edges(60); step(3);
    n_checks++; if (state !== 2'd2) begin n_fail++; $display("FAIL mid_play_state: got %0d expected 2", state); end
    start_btn = 1'b0;
    step(4);
    start_btn = 1'b1;
    step(8);
    n_checks++; if (state !== 2'd2) begin n_fail++; $display("FAIL play_start_ignored: got %0d expected 2", state); end
    rst_n = 1'b0;
    #1;
    n_checks++; if (state !== 2'd0) begin n_fail++; $display("FAIL async_reset_state: got %0d expected 0", state); end
    n_checks++; if (bar_move_speed !== 4'd0) begin n_fail++; $display("FAIL async_reset_speed: got %0d expected 0", bar_move_speed); end
    n_checks++; if (lives !== 2'd3) begin n_fail++; $display("FAIL async_reset_lives: got %0d expected 3", lives); end
    step(2);
    rst_n = 1'b1;
    step_count(20, br);
    n_checks++; if (state !== 2'd0) begin n_fail++; $display("FAIL held_btn_state: got %0d expected 0", state); end
    n_checks++; if (br !== 0) begin n_fail++; $display("FAIL held_btn_ball_reset: got %0d expected 0", br); end
    start_btn = 1'b0;
    step(4);
    start_btn = 1'b1;
    step(6);
    n_checks++; if (state !== 2'd1) begin n_fail++; $display("FAIL fresh_edge_state: got %0d expected 1", state); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_start();
    test_level();
    test_loss();
    test_collision();
    test_over();
    test_midgame_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
